// File: rtl/count_register.sv
// Bounded up-counter stage wrapped around an external W-bit incrementer.
// Optional build macro COUNT_REGISTER_AUTORELOAD_EN: terminal count reloads to 0 and keeps running.
module count_register #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] limit,
  input  logic [W-1:0] inc_s,
  input  logic         inc_cout,
  output logic [W-1:0] inc_a,
  output logic [W-1:0] cnt,
  output logic         busy,
  output logic         done,
  output logic         ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_n;
  logic [W-1:0] cnt_n;
  logic         ovf_n;
  logic         done_pulse;

  // The incrementer always sees the live count; all arithmetic happens there.
  assign inc_a = cnt;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ovf_n      = ovf;
    done_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (stop) begin
          state_n = IDLE;
        end else if (start) begin
          state_n = RUN;
          ovf_n   = 1'b0;
        end else if (load) begin
          cnt_n = load_val;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (en) begin
          if (cnt == limit) begin
`ifdef COUNT_REGISTER_AUTORELOAD_EN
            cnt_n      = '0;
            done_pulse = 1'b1;
`else
            state_n = DONE;
`endif
          end else begin
            cnt_n = inc_s;
            if (inc_cout) ovf_n = 1'b1;
          end
        end
      end
      DONE: begin
        if (stop) begin
          state_n = IDLE;
        end else if (start) begin
          state_n = RUN;
          cnt_n   = '0;
          ovf_n   = 1'b0;
        end else if (load) begin
          cnt_n = load_val;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // busy/done are registered decodes of the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
      busy  <= (state_n == RUN);
      done  <= (state_n == DONE) || done_pulse;
    end
  end

endmodule

// File: tb/tb_count_register.sv
// Randomized + directed bench for count_register against a behavioural counter model.
module tb_count_register;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, stop, en, load;
  logic [W-1:0] load_val, limit;
  logic [W-1:0] inc_s;
  logic         inc_cout;
  logic [W-1:0] inc_a, cnt;
  logic         busy, done, ovf;

  // Clock / reset block
  always #5 clk = ~clk;

  // Stand-in for the external incrementer.
  assign {inc_cout, inc_s} = {1'b0, inc_a} + 5'd1;

  count_register #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .en(en),
    .load(load), .load_val(load_val), .limit(limit),
    .inc_s(inc_s), .inc_cout(inc_cout), .inc_a(inc_a), .cnt(cnt),
    .busy(busy), .done(done), .ovf(ovf)
  );

  // Behavioural model: mode 0=idle, 1=running, 2=finished
  int m_mode = 0;
  int m_cnt  = 0;
  bit m_ovf  = 0;
  bit m_busy = 0;
  bit m_done = 0;
  bit chk_en = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  always @(posedge clk) begin
    bit pulse;
    pulse = 0;
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_ovf = 0;
    end else if (stop) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (start) begin m_mode = 1; m_ovf = 0; end
      else if (load) m_cnt = int'(load_val);
    end else if (m_mode == 1) begin
      if (en) begin
        if (m_cnt == int'(limit)) begin
`ifdef COUNT_REGISTER_AUTORELOAD_EN
          m_cnt = 0; pulse = 1;
`else
          m_mode = 2;
`endif
        end else begin
          if (m_cnt == (1 << W) - 1) m_ovf = 1;
          m_cnt = (m_cnt + 1) % (1 << W);
        end
      end
    end else begin
      if (start) begin m_mode = 1; m_cnt = 0; m_ovf = 0; end
      else if (load) m_cnt = int'(load_val);
    end
    m_busy = (m_mode == 1);
    m_done = (m_mode == 2) || pulse;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cnt",   int'(cnt),   m_cnt);
      check("inc_a", int'(inc_a), m_cnt);
      check("busy",  int'(busy),  int'(m_busy));
      check("done",  int'(done),  int'(m_done));
      check("ovf",   int'(ovf),   int'(m_ovf));
    end
  end

  // Hand-computed literal expectations: DUT and model both pinned.
  task automatic lit(input string name, input int c, input int b, input int d, input int o);
    check({name, ".cnt"},    int'(cnt),    c);
    check({name, ".busy"},   int'(busy),   b);
    check({name, ".done"},   int'(done),   d);
    check({name, ".ovf"},    int'(ovf),    o);
    check({name, ".m_cnt"},  m_cnt,        c);
    check({name, ".m_done"}, int'(m_done), d);
  endtask

  // Driver tasks
  task automatic idle_inputs();
    start = 0; stop = 0; en = 0; load = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int v);
    load = 1; load_val = W'(v); tick(1); load = 0;
  endtask

  task automatic do_start();
    start = 1; tick(1); start = 0;
  endtask

  initial begin
    idle_inputs();
    load_val = '0; limit = '0;
    rst_n = 0; start = 1;
    tick(2);
    rst_n = 1; start = 0;
    chk_en = 1;
    lit("reset", 0, 0, 0, 0);

`ifndef COUNT_REGISTER_AUTORELOAD_EN
    // basic count 0..5 then done
    limit = 5; do_start(); en = 1;
    tick(6);
    lit("basic", 5, 0, 1, 0);
    // restart from done with start+load together
    start = 1; load = 1; load_val = 9; tick(1); start = 0; load = 0;
    lit("restart", 0, 1, 0, 0);
    stop = 1; tick(1); stop = 0; en = 0;
    lit("stop", 0, 0, 0, 0);
    // load 13 and wrap to limit 2
    do_load(13); limit = 2; do_start(); en = 1;
    lit("wrap_entry", 13, 1, 0, 0);
    tick(6);
    lit("wrap", 2, 0, 1, 1);
    // enable gating then stop+start together
    stop = 1; tick(1); stop = 0; en = 0;
    do_load(0); limit = 9; do_start();
    en = 1; tick(1); en = 0; tick(1); en = 1; tick(1); en = 0; tick(1);
    lit("gating", 2, 1, 0, 0);
    stop = 1; start = 1; tick(1); idle_inputs();
    lit("stop_start", 2, 0, 0, 0);
    // entering run with cnt == limit
    do_load(4); limit = 4; do_start(); en = 1; tick(1);
    lit("at_limit", 4, 0, 1, 0);
    stop = 1; tick(1); idle_inputs();
`else
    limit = 3; do_start(); en = 1;
    tick(4);
    lit("reload", 0, 1, 1, 0);
    tick(1);
    lit("reload_next", 1, 1, 0, 0);
    tick(3);
    lit("reload_again", 0, 1, 1, 0);
    stop = 1; tick(1); idle_inputs();
    lit("reload_stop", 0, 0, 0, 0);
`endif

    // reset mid-run
    do_load(0); limit = 15; do_start(); en = 1;
    tick(7);
    lit("midrun", 7, 1, 0, 0);
    rst_n = 0; tick(1); rst_n = 1; en = 0;
    lit("midrun_rst", 0, 0, 0, 0);

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      stop     = ($urandom_range(0, 29) == 0);
      start    = ($urandom_range(0, 9) == 0);
      load     = ($urandom_range(0, 4) == 0);
      en       = ($urandom_range(0, 3) != 0);
      load_val = W'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) limit = W'($urandom_range(0, 15));
      tick(1);
    end
    idle_inputs();
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
